// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU slice: the default operand width and the
// 2-bit operation codes decoded by alu_core.
// ----------------------------------------------------------------------------
package alu_pkg;

    // Default operand / result width in bits.
    localparam int ALU_WIDTH = 4;

    // Operation select encoding carried on the 'sel' port.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath.
//
// Ports:
//   a      in  [WIDTH-1:0]  operand A, unsigned
//   b      in  [WIDTH-1:0]  operand B, unsigned
//   sel    in  [1:0]        operation select (see alu_pkg::alu_op_e)
//   result out [WIDTH-1:0]  operation result, ADD wraps modulo 2^WIDTH
//   carry  out              carry-out of ADD, 0 for logic operations
// ----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    // One extra bit so the adder's carry-out is kept rather than truncated.
    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned; that is what keeps this block free of latches.
        result = '0;
        carry  = 1'b0;
        case (alu_op_e'(sel))
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule : alu_core

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
// Single-cycle-latency registered ALU. Operands are sampled on a rising edge
// with in_valid high; the result, carry and zero flag appear after that edge
// together with a one-cycle out_valid pulse. With in_valid low the outputs
// hold. No backpressure: one operation may be accepted every cycle.
//
// Ports:
//   clk       in                single clock, rising edge
//   rst       in                synchronous, active-high reset
//   in_valid  in                a, b, sel are accepted this cycle when high
//   a         in  [WIDTH-1:0]   operand A, unsigned
//   b         in  [WIDTH-1:0]   operand B, unsigned
//   sel       in  [1:0]         00 ADD, 01 AND, 10 OR, 11 XOR
//   result    out [WIDTH-1:0]   registered result
//   carry     out               registered ADD carry-out, 0 for logic ops
//   zero      out               high while the registered result is 0
//   out_valid out               one-cycle pulse per accepted operation
// ----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH-1:0] core_result;
    logic             core_carry;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a),
        .b      (b),
        .sel    (sel),
        .result (core_result),
        .carry  (core_carry)
    );

    // NOTE: state registers use non-blocking assignments so every flop in
    // this block updates from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and wins over in_valid, so an operation
        // presented during reset is dropped rather than registered.
        if (rst) begin
            result    <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Load only on accepted operations; the registers hold otherwise,
            // which also keeps undriven inputs during idle cycles out of them.
            if (in_valid) begin
                result <= core_result;
                carry  <= core_carry;
            end
        end
    end

    // Derived from the registered value, so it reads 1 straight out of reset.
    assign zero = (result == '0);

endmodule : alu

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu. A driver issues directed and random operations
// and pushes the expected response, tagged with the cycle it must appear in,
// into a queue. A monitor on the falling edge compares the DUT outputs each
// cycle against the queue head, the held value, or the reset state.
// ----------------------------------------------------------------------------
module tb_alu;
    import alu_pkg::*;

    localparam int W = ALU_WIDTH;

    typedef struct {
        int          due;
        int unsigned res;
        int unsigned cy;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         out_valid;

    alu #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          armed    = 1'b0;
    bit          rst_seen = 1'b0;
    int unsigned last_res = 0;
    int unsigned last_cy  = 0;

    task automatic check(input string name, input int unsigned actual,
                         input int unsigned expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, actual, expected);
        end
    endtask

    // Edge bookkeeping: cycle count and whether reset was applied at this edge.
    always @(posedge clk) begin
        cyc++;
        rst_seen = rst;
        armed    = 1'b1;
    end

    // Monitor: every cycle is exactly one of reset, a result, or an idle hold.
    always @(negedge clk) begin
        if (armed) begin
            if (rst_seen) begin
                check("rst_result", result, 0);
                check("rst_carry", carry, 0);
                check("rst_zero", zero, 1);
                check("rst_out_valid", out_valid, 0);
                last_res = 0;
                last_cy  = 0;
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_valid", out_valid, 1);
                check("result", result, e.res);
                check("carry", carry, e.cy);
                check("zero", zero, (e.res == 0) ? 1 : 0);
                last_res = e.res;
                last_cy  = e.cy;
            end else begin
                check("idle_out_valid", out_valid, 0);
                check("hold_result", result, last_res);
                check("hold_carry", carry, last_cy);
                check("hold_zero", zero, (last_res == 0) ? 1 : 0);
            end
        end
    end

    // Reference model: plain unsigned arithmetic on the operation's meaning.
    function automatic exp_t model(input int unsigned aa, input int unsigned bb,
                                   input logic [1:0] s, input int due);
        exp_t        e;
        int unsigned full;
        int unsigned modulus;
        modulus = 1 << W;
        e.due   = due;
        e.cy    = 0;
        case (s)
            2'b00: begin
                full = aa + bb;
                e.res = full % modulus;
                e.cy  = (full >= modulus) ? 1 : 0;
            end
            2'b01:   e.res = aa & bb;
            2'b10:   e.res = aa | bb;
            default: e.res = aa ^ bb;
        endcase
        return e;
    endfunction

    // Present one cycle of stimulus; an accepted operation is due next cycle.
    task automatic drive(input bit v, input int unsigned aa, input int unsigned bb,
                         input logic [1:0] s, input bit r);
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        a        = W'(aa);
        b        = W'(bb);
        sel      = s;
        if (v && !r)
            exp_q.push_back(model(aa, bb, s, cyc + 1));
    endtask

    task automatic idle_x();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        sel      = 'x;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sel      = 2'b00;

        drive(0, 0, 0, 2'b00, 1);
        drive(0, 0, 0, 2'b00, 1);

        // Basic ADD, then ADD without and with wrap-around.
        drive(1, 4'b0011, 4'b0101, 2'b00, 0);
        drive(0, 0, 0, 2'b00, 0);
        drive(1, 4'b1001, 4'b0011, 2'b00, 0);
        drive(1, 4'b1111, 4'b0001, 2'b00, 0);
        drive(0, 0, 0, 2'b00, 0);

        // Logic operations on the same operands.
        drive(1, 4'b1100, 4'b1010, 2'b01, 0);
        drive(1, 4'b1100, 4'b1010, 2'b10, 0);
        drive(1, 4'b1100, 4'b1010, 2'b11, 0);

        // Back-to-back ADD, AND, OR.
        drive(1, 4'b0011, 4'b0101, 2'b00, 0);
        drive(1, 4'b1100, 4'b1010, 2'b01, 0);
        drive(1, 4'b1100, 4'b1010, 2'b10, 0);

        // Idle with changing and undriven operands: outputs must hold.
        drive(0, 4'b0111, 4'b0110, 2'b00, 0);
        drive(0, 4'b1111, 4'b1111, 2'b11, 0);
        idle_x();
        idle_x();

        // Reset coinciding with a valid ADD discards it; next op completes.
        drive(1, 4'b0011, 4'b0101, 2'b00, 1);
        drive(1, 4'b0110, 4'b0011, 2'b11, 0);
        drive(0, 0, 0, 2'b00, 0);

        // Randomized traffic with occasional idles and resets.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, (1 << W) - 1),
                  $urandom_range(0, (1 << W) - 1),
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 24) == 0);
        end

        // Drain: every queued response must have been consumed in time.
        for (int i = 0; i < 4; i++)
            drive(0, 0, 0, 2'b00, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu
